axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
AXI4 subordinate (responder) that terminates the out_* side of an AXI relay pipeline with an on-chip RAM, so kernels can be simulated and bring-up tested without an external memory controller.
Independent read and write engines, one outstanding burst each, INCR full-width bursts only, OKAY/SLVERR responses.

Parameters:
C_M_AXI_ID_WIDTH, 8, width of AWID/BID/ARID/RID
C_M_AXI_ADDR_WIDTH, 32, byte address width
C_M_AXI_DATA_WIDTH, 512, data bus width in bits (power of two, >=32); WSTRB width = C_M_AXI_DATA_WIDTH/8, derived locally
MEM_DEPTH_LOG2, 10, log2 of RAM depth in data words

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  reset, synchronous active-high
s_AWVALID  in  1  write address valid
s_AWREADY  out  1  write address ready
s_AWADDR  in  C_M_AXI_ADDR_WIDTH  write start byte address
s_AWLEN  in  8  write beats minus one
s_AWID  in  C_M_AXI_ID_WIDTH  write transaction ID
s_WVALID  in  1  write data valid
s_WREADY  out  1  write data ready
s_WDATA  in  C_M_AXI_DATA_WIDTH  write data
s_WSTRB  in  C_M_AXI_DATA_WIDTH/8  byte enables
s_WLAST  in  1  last write beat
s_BVALID  out  1  write response valid
s_BREADY  in  1  write response ready
s_BRESP  out  2  OKAY 2'b00 / SLVERR 2'b10
s_BID  out  C_M_AXI_ID_WIDTH  echoed AWID
s_ARVALID  in  1  read address valid
s_ARREADY  out  1  read address ready
s_ARADDR  in  C_M_AXI_ADDR_WIDTH  read start byte address
s_ARLEN  in  8  read beats minus one
s_ARID  in  C_M_AXI_ID_WIDTH  read transaction ID
s_RVALID  out  1  read data valid
s_RREADY  in  1  read data ready
s_RDATA  out  C_M_AXI_DATA_WIDTH  read data
s_RLAST  out  1  last read beat
s_RID  out  C_M_AXI_ID_WIDTH  echoed ARID
s_RRESP  out  2  always 2'b00
(AxSIZE/AxBURST not ported: full-width INCR is implied; upstream drives constants.)

Behaviour:
- Word index = addr >> log2(DATA_WIDTH/8), low byte bits ignored; index taken modulo 2^MEM_DEPTH_LOG2 and increments per beat, wrapping silently at depth.
- Reset (ap_rst=1 sampled at edge): both FSMs to IDLE; while asserted all READY/VALID outputs 0, BRESP/RRESP/RLAST/IDs 0. RAM contents not cleared. Reset mid-burst abandons the burst, no response issued.
- Write FSM W_IDLE->W_DATA->W_RESP. W_IDLE: AWREADY=1; on AWVALID latch index, AWID, AWLEN, clear beat count. W_DATA: WREADY=1; each WVALID beat writes bytes enabled by WSTRB, index++, count++; on WLAST go W_RESP; BRESP=SLVERR if WLAST beat count != AWLEN, else OKAY. Beats past AWLEN without WLAST are still written (SLVERR latched). W_RESP: BVALID=1 held stable until BREADY, then W_IDLE. AW->first WREADY: 1 cycle.
- Read FSM R_IDLE->R_FETCH->R_DATA. R_IDLE: ARREADY=1; latch index, ARID, ARLEN. R_FETCH: issue synchronous RAM read (1-cycle latency). R_DATA: RVALID=1, RDATA/RLAST/RID held stable until RREADY; RLAST=1 iff beat==ARLEN; on handshake go R_FETCH (next beat) or R_IDLE after last. Throughput 1 beat/2 cycles; first RVALID 2 cycles after AR handshake.
- Simultaneous read and write of same word in same cycle: read returns old data (read-before-write).
- Read and write engines fully independent; no ordering between channels.

Decomposition:
- Shared package: AXI response codes (RESP_OKAY, RESP_SLVERR), FSM state encodings.
- One sub-module: axi_mem_responder_ram, simple dual-port byte-enable synchronous RAM (1 write port, 1 read port).

Test Plan:
- Reset: hold ap_rst 3 cycles with AWVALID=ARVALID=1 -> AWREADY=ARREADY=BVALID=RVALID=0 throughout; AWREADY=ARREADY=1 first cycle after release.
- Write 4 beats AWADDR=0x40 (DATA 512), AWID=5, WSTRB all-ones, data 0xA0..0xA3 -> BVALID with BID=5, BRESP=00; read ARADDR=0x40 ARLEN=3 ARID=9 -> RDATA 0xA0..0xA3, RLAST on 4th only, RID=9.
- Partial strobe: write WSTRB=0x1 data 0xFF over word 0x1234 -> readback low byte 0xFF, remaining bytes unchanged.
- Early WLAST: AWLEN=3, WLAST on beat 2 -> BRESP=2'b10, next AW accepted after BREADY.
- Backpressure: hold RREADY=0 for 5 cycles mid-burst, BREADY=0 for 5 cycles -> RVALID/RDATA/RLAST and BVALID/BID stable, no beat lost or duplicated.
- Wrap: MEM_DEPTH_LOG2=4, write 2 beats at word 15 -> second beat lands in word 0; concurrent read of word 0 same cycle returns pre-write data.

Source files
------------

// File: rtl/axi_mem_responder_pkg.sv
// Shared definitions for the AXI memory responder: response codes and FSM encodings.
package axi_mem_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Simple dual-port synchronous RAM, one byte-enabled write port and one read port.
// A read and a write of the same word in the same cycle returns the old contents.
module axi_mem_responder_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by on-chip RAM: independent single-outstanding read and
// write engines, full-width INCR bursts, OKAY/SLVERR write responses.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 8,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MEM_DEPTH_LOG2     = 10
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst,

    input  logic                            s_AWVALID,
    output logic                            s_AWREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_AWADDR,
    input  logic [7:0]                      s_AWLEN,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     s_AWID,

    input  logic                            s_WVALID,
    output logic                            s_WREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_WSTRB,
    input  logic                            s_WLAST,

    output logic                            s_BVALID,
    input  logic                            s_BREADY,
    output logic [1:0]                      s_BRESP,
    output logic [C_M_AXI_ID_WIDTH-1:0]     s_BID,

    input  logic                            s_ARVALID,
    output logic                            s_ARREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_ARADDR,
    input  logic [7:0]                      s_ARLEN,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     s_ARID,

    output logic                            s_RVALID,
    input  logic                            s_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_RDATA,
    output logic                            s_RLAST,
    output logic [C_M_AXI_ID_WIDTH-1:0]     s_RID,
    output logic [1:0]                      s_RRESP
);

    localparam int STRB_W     = C_M_AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);

    localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = 1;
    localparam logic [7:0]                CNT_ONE = 8'd1;

    wr_state_e wr_state, wr_state_nxt;
    rd_state_e rd_state, rd_state_nxt;

    logic [MEM_DEPTH_LOG2-1:0]   wr_idx;
    logic [C_M_AXI_ID_WIDTH-1:0] wr_id;
    logic [7:0]                  wr_len;
    logic [7:0]                  wr_cnt;
    logic                        wr_err;
    logic [1:0]                  wr_resp;
    logic                        ram_we;

    logic [MEM_DEPTH_LOG2-1:0]   rd_idx;
    logic [C_M_AXI_ID_WIDTH-1:0] rd_id;
    logic [7:0]                  rd_len;
    logic [7:0]                  rd_beat;
    logic                        rd_last;
    logic                        ram_re;

    // Byte bits below the word index and address bits above the RAM depth are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_AWADDR, s_ARADDR};

    assign rd_last = (rd_beat == rd_len);
    assign s_RRESP = RESP_OKAY;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_state <= W_IDLE;
            wr_idx   <= '0;
            wr_id    <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
            wr_resp  <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_nxt;
            case (wr_state)
                W_IDLE: begin
                    if (s_AWVALID) begin
                        wr_idx <= s_AWADDR[BYTE_SHIFT +: MEM_DEPTH_LOG2];
                        wr_id  <= s_AWID;
                        wr_len <= s_AWLEN;
                        wr_cnt <= '0;
                        wr_err <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (s_WVALID) begin
                        wr_idx <= wr_idx + IDX_ONE;
                        wr_cnt <= wr_cnt + CNT_ONE;
                        // Overrun is sticky so a burst that wraps the 8-bit count still errors.
                        if (s_WLAST) begin
                            wr_resp <= (wr_err || (wr_cnt != wr_len)) ? RESP_SLVERR : RESP_OKAY;
                        end else if (wr_cnt == wr_len) begin
                            wr_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        s_AWREADY    = 1'b0;
        s_WREADY     = 1'b0;
        s_BVALID     = 1'b0;
        s_BRESP      = RESP_OKAY;
        s_BID        = '0;
        ram_we       = 1'b0;
        if (!ap_rst) begin
            case (wr_state)
                W_IDLE: begin
                    s_AWREADY = 1'b1;
                    if (s_AWVALID) wr_state_nxt = W_DATA;
                end
                W_DATA: begin
                    s_WREADY = 1'b1;
                    if (s_WVALID) begin
                        ram_we = 1'b1;
                        if (s_WLAST) wr_state_nxt = W_RESP;
                    end
                end
                W_RESP: begin
                    s_BVALID = 1'b1;
                    s_BRESP  = wr_resp;
                    s_BID    = wr_id;
                    if (s_BREADY) wr_state_nxt = W_IDLE;
                end
                default: wr_state_nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_id    <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            case (rd_state)
                R_IDLE: begin
                    if (s_ARVALID) begin
                        rd_idx  <= s_ARADDR[BYTE_SHIFT +: MEM_DEPTH_LOG2];
                        rd_id   <= s_ARID;
                        rd_len  <= s_ARLEN;
                        rd_beat <= '0;
                    end
                end
                R_DATA: begin
                    if (s_RREADY && !rd_last) begin
                        rd_idx  <= rd_idx + IDX_ONE;
                        rd_beat <= rd_beat + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM output register only reloads in R_FETCH, which keeps RDATA stable under backpressure.
    always_comb begin
        rd_state_nxt = rd_state;
        s_ARREADY    = 1'b0;
        s_RVALID     = 1'b0;
        s_RLAST      = 1'b0;
        s_RID        = '0;
        ram_re       = 1'b0;
        if (!ap_rst) begin
            case (rd_state)
                R_IDLE: begin
                    s_ARREADY = 1'b1;
                    if (s_ARVALID) rd_state_nxt = R_FETCH;
                end
                R_FETCH: begin
                    ram_re       = 1'b1;
                    rd_state_nxt = R_DATA;
                end
                R_DATA: begin
                    s_RVALID = 1'b1;
                    s_RLAST  = rd_last;
                    s_RID    = rd_id;
                    if (s_RREADY) rd_state_nxt = rd_last ? R_IDLE : R_FETCH;
                end
                default: rd_state_nxt = R_IDLE;
            endcase
        end
    end

    axi_mem_responder_ram #(
        .DATA_WIDTH (C_M_AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk   (ap_clk),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (s_WDATA),
        .wbe   (s_WSTRB),
        .re    (ram_re),
        .raddr (rd_idx),
        .rdata (s_RDATA)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a 16-word RAM so address wrap is reachable.
module tb_axi_mem_responder;

    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 512;
    localparam int SW  = DW / 8;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic            s_AWVALID, s_AWREADY;
    logic [AW-1:0]   s_AWADDR;
    logic [7:0]      s_AWLEN;
    logic [IDW-1:0]  s_AWID;
    logic            s_WVALID, s_WREADY;
    logic [DW-1:0]   s_WDATA;
    logic [SW-1:0]   s_WSTRB;
    logic            s_WLAST;
    logic            s_BVALID, s_BREADY;
    logic [1:0]      s_BRESP;
    logic [IDW-1:0]  s_BID;
    logic            s_ARVALID, s_ARREADY;
    logic [AW-1:0]   s_ARADDR;
    logic [7:0]      s_ARLEN;
    logic [IDW-1:0]  s_ARID;
    logic            s_RVALID, s_RREADY;
    logic [DW-1:0]   s_RDATA;
    logic            s_RLAST;
    logic [IDW-1:0]  s_RID;
    logic [1:0]      s_RRESP;

    int check_count = 0;
    int error_count = 0;

    logic [DW-1:0] wbeat_data [0:7];
    logic [SW-1:0] wbeat_strb [0:7];
    logic [DW-1:0] rexp       [0:7];

    always #5 ap_clk = ~ap_clk;

    axi_mem_responder #(
        .C_M_AXI_ID_WIDTH   (IDW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .MEM_DEPTH_LOG2     (4)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .s_AWVALID (s_AWVALID),
        .s_AWREADY (s_AWREADY),
        .s_AWADDR  (s_AWADDR),
        .s_AWLEN   (s_AWLEN),
        .s_AWID    (s_AWID),
        .s_WVALID  (s_WVALID),
        .s_WREADY  (s_WREADY),
        .s_WDATA   (s_WDATA),
        .s_WSTRB   (s_WSTRB),
        .s_WLAST   (s_WLAST),
        .s_BVALID  (s_BVALID),
        .s_BREADY  (s_BREADY),
        .s_BRESP   (s_BRESP),
        .s_BID     (s_BID),
        .s_ARVALID (s_ARVALID),
        .s_ARREADY (s_ARREADY),
        .s_ARADDR  (s_ARADDR),
        .s_ARLEN   (s_ARLEN),
        .s_ARID    (s_ARID),
        .s_RVALID  (s_RVALID),
        .s_RREADY  (s_RREADY),
        .s_RDATA   (s_RDATA),
        .s_RLAST   (s_RLAST),
        .s_RID     (s_RID),
        .s_RRESP   (s_RRESP)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reset held with address valids asserted; everything must stay quiet until release.
    task automatic applyStimulus();
        ap_rst    = 1'b1;
        s_AWVALID = 1'b1;
        s_ARVALID = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            checkOutput("reset_quiet",
                        {s_AWREADY, s_ARREADY, s_BVALID, s_RVALID, s_WREADY, s_RLAST, s_BRESP, s_BID, s_RID},
                        '0);
        end
        ap_rst    = 1'b0;
        s_AWVALID = 1'b0;
        s_ARVALID = 1'b0;
        #1;
        checkOutput("reset_release", {s_AWREADY, s_ARREADY}, 2'b11);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                               input int nbeats, input int bstall, input logic [1:0] exp_resp);
        int n;
        s_AWVALID = 1'b1;
        s_AWADDR  = addr;
        s_AWLEN   = len;
        s_AWID    = id;
        n = 0;
        while (!s_AWREADY && n < 20) begin @(negedge ap_clk); n++; end
        checkOutput("awready", s_AWREADY, 1'b1);
        @(negedge ap_clk);
        s_AWVALID = 1'b0;
        checkOutput("wready_latency", s_WREADY, 1'b1);
        for (int b = 0; b < nbeats; b++) begin
            s_WVALID = 1'b1;
            s_WDATA  = wbeat_data[b];
            s_WSTRB  = wbeat_strb[b];
            s_WLAST  = (b == nbeats - 1);
            n = 0;
            while (!s_WREADY && n < 20) begin @(negedge ap_clk); n++; end
            @(negedge ap_clk);
        end
        s_WVALID = 1'b0;
        s_WLAST  = 1'b0;
        n = 0;
        while (!s_BVALID && n < 20) begin @(negedge ap_clk); n++; end
        checkOutput("bvalid", s_BVALID, 1'b1);
        for (int c = 0; c < bstall; c++) begin
            @(negedge ap_clk);
            checkOutput("b_hold", {s_BVALID, s_BID, s_BRESP}, {1'b1, id, exp_resp});
        end
        checkOutput("bid", s_BID, id);
        checkOutput("bresp", s_BRESP, exp_resp);
        s_BREADY = 1'b1;
        @(negedge ap_clk);
        s_BREADY = 1'b0;
        checkOutput("b_done", {s_BVALID, s_AWREADY}, 2'b01);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                              input int stall_beat, input int stall_cycles);
        int n;
        s_ARVALID = 1'b1;
        s_ARADDR  = addr;
        s_ARLEN   = len;
        s_ARID    = id;
        n = 0;
        while (!s_ARREADY && n < 20) begin @(negedge ap_clk); n++; end
        checkOutput("arready", s_ARREADY, 1'b1);
        @(negedge ap_clk);
        s_ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!s_RVALID && n < 20) begin @(negedge ap_clk); n++; end
            checkOutput("rvalid", s_RVALID, 1'b1);
            if (b == 0) checkOutput("rvalid_latency", n, 1);
            if (b == stall_beat) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    @(negedge ap_clk);
                    checkOutput("r_hold_data", s_RDATA, rexp[b]);
                    checkOutput("r_hold_ctl", {s_RVALID, s_RLAST, s_RID}, {1'b1, (b == int'(len)), id});
                end
            end
            checkOutput("rdata", s_RDATA, rexp[b]);
            checkOutput("rlast", s_RLAST, (b == int'(len)));
            checkOutput("rid_rresp", {s_RID, s_RRESP}, {id, 2'b00});
            s_RREADY = 1'b1;
            @(negedge ap_clk);
            s_RREADY = 1'b0;
        end
        checkOutput("r_done", {s_RVALID, s_ARREADY}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_AWADDR = '0; s_AWLEN = '0; s_AWID = '0;
        s_WVALID = 1'b0; s_WDATA = '0; s_WSTRB = '0; s_WLAST = 1'b0;
        s_BREADY = 1'b0;
        s_ARADDR = '0; s_ARLEN = '0; s_ARID = '0;
        s_RREADY = 1'b0;
        applyStimulus();

        $display("[TB] 4-beat burst write/read with read backpressure");
        for (int b = 0; b < 4; b++) begin
            wbeat_data[b] = DW'(8'hA0 + b);
            wbeat_strb[b] = '1;
            rexp[b]       = DW'(8'hA0 + b);
        end
        write_burst(32'h40, 8'd3, 8'd5, 4, 0, 2'b00);
        read_burst(32'h40, 8'd3, 8'd9, 1, 5);

        $display("[TB] partial strobe at word 0x1234");
        wbeat_data[0] = {16{32'h1122_3344}};
        wbeat_strb[0] = '1;
        write_burst(32'h0004_8D00, 8'd0, 8'd1, 1, 0, 2'b00);
        wbeat_data[0] = '1;
        wbeat_strb[0] = 64'h1;
        write_burst(32'h0004_8D00, 8'd0, 8'd2, 1, 0, 2'b00);
        rexp[0] = {{15{32'h1122_3344}}, 32'h1122_33FF};
        read_burst(32'h0004_8D00, 8'd0, 8'd4, -1, 0);

        $display("[TB] early WLAST with response backpressure");
        for (int b = 0; b < 3; b++) begin
            wbeat_data[b] = DW'(8'hB0 + b);
            wbeat_strb[b] = '1;
        end
        write_burst(32'h80, 8'd3, 8'd6, 3, 5, 2'b10);

        $display("[TB] overlong burst still writes extra beat");
        for (int b = 0; b < 3; b++) begin
            wbeat_data[b] = DW'(8'hC0 + b);
            wbeat_strb[b] = '1;
            rexp[b]       = DW'(8'hC0 + b);
        end
        write_burst(32'h200, 8'd1, 8'd8, 3, 0, 2'b10);
        read_burst(32'h200, 8'd2, 8'd10, -1, 0);

        $display("[TB] wrap at depth with same-cycle read of word 0");
        wbeat_data[0] = DW'(8'hD0);
        wbeat_strb[0] = '1;
        write_burst(32'h0, 8'd0, 8'd2, 1, 0, 2'b00);
        s_AWVALID = 1'b1; s_AWADDR = 32'h3C0; s_AWLEN = 8'd1; s_AWID = 8'd7;
        checkOutput("wrap_awready", s_AWREADY, 1'b1);
        @(negedge ap_clk);
        s_AWVALID = 1'b0;
        s_ARVALID = 1'b1; s_ARADDR = 32'h0; s_ARLEN = 8'd0; s_ARID = 8'd3;
        s_WVALID = 1'b1; s_WDATA = DW'(8'hEF); s_WSTRB = '1; s_WLAST = 1'b0;
        checkOutput("wrap_ready", {s_ARREADY, s_WREADY}, 2'b11);
        @(negedge ap_clk);
        s_ARVALID = 1'b0;
        s_WDATA = DW'(8'hE0); s_WLAST = 1'b1;
        checkOutput("wrap_fetch", {s_RVALID, s_WREADY}, 2'b01);
        @(negedge ap_clk);
        s_WVALID = 1'b0; s_WLAST = 1'b0;
        checkOutput("wrap_rdata_old", s_RDATA, DW'(8'hD0));
        checkOutput("wrap_r_ctl", {s_RVALID, s_RLAST, s_RID}, {1'b1, 1'b1, 8'd3});
        checkOutput("wrap_b", {s_BVALID, s_BRESP, s_BID}, {1'b1, 2'b00, 8'd7});
        s_RREADY = 1'b1; s_BREADY = 1'b1;
        @(negedge ap_clk);
        s_RREADY = 1'b0; s_BREADY = 1'b0;
        rexp[0] = DW'(8'hEF);
        rexp[1] = DW'(8'hE0);
        read_burst(32'h3C0, 8'd1, 8'd11, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
